// File: rtl/drbe_seq_pkg.sv
// Shared definitions for the DRBE boot sequencer: state encoding, default
// phase durations, and small state-classification helpers.
package drbe_seq_pkg;

    // Encoding follows bring-up order; IDLE must stay 4'h0.
    typedef enum logic [3:0] {
        StIdle      = 4'h0,
        StInit      = 4'h1,
        StSrst      = 4'h2,
        StGap0      = 4'h3,
        StLoad      = 4'h4,
        StGap1      = 4'h5,
        StBootUp    = 4'h6,
        StBootDrain = 4'h7,
        StParse     = 4'h8,
        StTblUp     = 4'h9,
        StTblUpd    = 4'hA,
        StSettle    = 4'hB,
        StStart     = 4'hC,
        StRun       = 4'hD
    } drbe_state_e;

    localparam int unsigned DEF_CNT_WIDTH      = 11;
    localparam int unsigned DEF_INIT_CYCLES    = 1050;  // N_sample sweep plus margin
    localparam int unsigned DEF_SRST_CYCLES    = 3;
    localparam int unsigned DEF_UPLOAD1_CYCLES = 20;
    localparam int unsigned DEF_UPLOAD2_CYCLES = 26;
    localparam int unsigned DEF_GAP_CYCLES     = 6;
    localparam int unsigned DEF_PARSE_CYCLES   = 38;
    localparam int unsigned DEF_SETTLE_CYCLES  = 85;

    // busy drops as soon as START is reached so it falls with the start pulse.
    function automatic logic seq_is_busy(drbe_state_e s);
        return !(s inside {StIdle, StStart, StRun});
    endfunction

    // table_parse is held from PARSE through RUN, including rescen loops.
    function automatic logic seq_table_parse(drbe_state_e s);
        return s inside {StParse, StTblUp, StTblUpd, StSettle, StStart, StRun};
    endfunction

endpackage

// File: rtl/drbe_phase_timer.sv
// Loadable down-counter that times each sequencer phase; o_zero marks the
// final cycle of the current phase.
module drbe_phase_timer #(
    parameter int unsigned CNT_WIDTH = 11
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    output logic                 o_zero
);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/drbe_boot_sequencer.sv
// DRBE local-controller bring-up / scenario-change sequencer.
// Optional feature macro: DRBE_SEQ_SRAM_INIT_EN adds the INIT, SRST and GAP0
// phases (init_sram / soft_reset). Without it, go jumps straight to LOAD.
module drbe_boot_sequencer
    import drbe_seq_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int unsigned INIT_CYCLES    = DEF_INIT_CYCLES,
    parameter int unsigned SRST_CYCLES    = DEF_SRST_CYCLES,
    parameter int unsigned UPLOAD1_CYCLES = DEF_UPLOAD1_CYCLES,
    parameter int unsigned UPLOAD2_CYCLES = DEF_UPLOAD2_CYCLES,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned PARSE_CYCLES   = DEF_PARSE_CYCLES,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       go,
    input  logic       rescen,
    input  logic       dft_clk_in,
    output logic       init_sram,
    output logic       soft_reset,
    output logic       load,
    output logic       upload,
    output logic       boot_up,
    output logic       table_parse,
    output logic       boot_up_local,
    output logic       boot_up_table_update,
    output logic       start,
    output logic       write_start,
    output logic       input_valid,
    output logic       glob_scen_noc_input_valid,
    output logic       busy,
    output logic [3:0] state_o
);

    drbe_state_e          r_state;
    drbe_state_e          w_state_next;
    logic [CNT_WIDTH-1:0] w_load_val;
    logic                 w_enter;
    logic                 w_zero;

    logic r_load, r_upload, r_boot_up, r_table_parse, r_boot_up_local;
    logic r_tbl_update, r_start, r_write_start, r_input_valid, r_glob_valid, r_busy;
`ifdef DRBE_SEQ_SRAM_INIT_EN
    logic r_init_sram, r_soft_reset;
`endif

    // Next-state: timed phases advance on the counter's last cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
`ifdef DRBE_SEQ_SRAM_INIT_EN
            StIdle:      if (go) w_state_next = StInit;
            StInit:      if (w_zero) w_state_next = StSrst;
            StSrst:      if (w_zero) w_state_next = StGap0;
            StGap0:      if (w_zero) w_state_next = StLoad;
`else
            StIdle:      if (go) w_state_next = StLoad;
`endif
            StLoad:      if (w_zero) w_state_next = StGap1;
            StGap1:      if (w_zero) w_state_next = StBootUp;
            StBootUp:    if (w_zero) w_state_next = StBootDrain;
            StBootDrain: if (w_zero) w_state_next = StParse;
            StParse:     if (w_zero) w_state_next = StTblUp;
            StTblUp:     if (w_zero) w_state_next = StTblUpd;
            StTblUpd:    if (w_zero) w_state_next = StSettle;
            StSettle:    if (w_zero) w_state_next = StStart;
            StStart:     if (w_zero) w_state_next = StRun;
            StRun:       if (rescen) w_state_next = StTblUp;
            default:     w_state_next = StIdle;
        endcase
    end

    // Phase length minus one for the state being entered.
    always_comb begin
        w_load_val = '0;
        case (w_state_next)
            StInit:      w_load_val = CNT_WIDTH'(INIT_CYCLES - 1);
            StSrst:      w_load_val = CNT_WIDTH'(SRST_CYCLES - 1);
            StGap0,
            StGap1,
            StBootDrain: w_load_val = CNT_WIDTH'(GAP_CYCLES - 1);
            StBootUp:    w_load_val = CNT_WIDTH'(UPLOAD1_CYCLES - 1);
            StParse:     w_load_val = CNT_WIDTH'(PARSE_CYCLES - 1);
            StTblUp:     w_load_val = CNT_WIDTH'(UPLOAD2_CYCLES - 1);
            StSettle:    w_load_val = CNT_WIDTH'(SETTLE_CYCLES - 1);
            default:     w_load_val = '0;
        endcase
    end

    assign w_enter = (w_state_next != r_state);

    drbe_phase_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .i_clk      (CLK),
        .i_reset    (reset),
        .i_load     (w_enter),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // State register plus Moore outputs decoded from the state being entered,
    // so every strobe changes on the same edge as the state.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state         <= StIdle;
            r_load          <= 1'b0;
            r_upload        <= 1'b0;
            r_boot_up       <= 1'b0;
            r_table_parse   <= 1'b0;
            r_boot_up_local <= 1'b0;
            r_tbl_update    <= 1'b0;
            r_start         <= 1'b0;
            r_write_start   <= 1'b0;
            r_input_valid   <= 1'b0;
            r_glob_valid    <= 1'b0;
            r_busy          <= 1'b0;
`ifdef DRBE_SEQ_SRAM_INIT_EN
            r_init_sram     <= 1'b0;
            r_soft_reset    <= 1'b0;
`endif
        end else begin
            r_state         <= w_state_next;
            r_load          <= (w_state_next == StLoad);
            r_upload        <= (w_state_next inside {StBootUp, StTblUp});
            r_boot_up       <= (w_state_next inside {StBootUp, StBootDrain});
            r_table_parse   <= seq_table_parse(w_state_next);
            r_boot_up_local <= (w_state_next == StParse);
            r_tbl_update    <= (w_state_next == StTblUpd);
            r_start         <= (w_state_next == StStart);
            r_write_start   <= r_write_start | (w_state_next == StStart);
            r_busy          <= seq_is_busy(w_state_next);
            // Valid gating uses the current boot_up, hence the one-cycle tail.
            r_input_valid   <= dft_clk_in & r_boot_up;
            r_glob_valid    <= dft_clk_in & ~r_boot_up & (r_state != StIdle);
`ifdef DRBE_SEQ_SRAM_INIT_EN
            r_init_sram     <= (w_state_next == StInit);
            r_soft_reset    <= (w_state_next == StSrst);
`endif
        end
    end

`ifdef DRBE_SEQ_SRAM_INIT_EN
    assign init_sram  = r_init_sram;
    assign soft_reset = r_soft_reset;
`else
    assign init_sram  = 1'b0;
    assign soft_reset = 1'b0;
`endif
    assign load                      = r_load;
    assign upload                    = r_upload;
    assign boot_up                   = r_boot_up;
    assign table_parse               = r_table_parse;
    assign boot_up_local             = r_boot_up_local;
    assign boot_up_table_update      = r_tbl_update;
    assign start                     = r_start;
    assign write_start               = r_write_start;
    assign input_valid               = r_input_valid;
    assign glob_scen_noc_input_valid = r_glob_valid;
    assign busy                      = r_busy;
    assign state_o                   = r_state;

endmodule

// File: tb/tb_drbe_boot_sequencer.sv
// Self-checking bench for drbe_boot_sequencer. Model: the bring-up is a
// timeline of (state, duration) phases; the expected state is found from the
// cycles elapsed since the last accepted go/rescen.
module tb_drbe_boot_sequencer;

`ifdef DRBE_SEQ_SRAM_INIT_EN
    localparam int EXP_START = 1243;
    localparam int EXP_INIT  = 1050;
    localparam int EXP_LOAD  = 1060;
    localparam int RST_AT    = 490;
`else
    localparam int EXP_START = 184;
    localparam int EXP_INIT  = 0;
    localparam int EXP_LOAD  = 1;
    localparam int RST_AT    = 40;
`endif

    logic clk = 1'b0;
    logic rst, go, rescen, dft;
    logic init_sram, soft_reset, load, upload, boot_up, table_parse, boot_up_local;
    logic boot_up_table_update, start, write_start, input_valid, glob_valid, busy;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    drbe_boot_sequencer dut (
        .CLK                       (clk),
        .reset                     (rst),
        .go                        (go),
        .rescen                    (rescen),
        .dft_clk_in                (dft),
        .init_sram                 (init_sram),
        .soft_reset                (soft_reset),
        .load                      (load),
        .upload                    (upload),
        .boot_up                   (boot_up),
        .table_parse               (table_parse),
        .boot_up_local             (boot_up_local),
        .boot_up_table_update      (boot_up_table_update),
        .start                     (start),
        .write_start               (write_start),
        .input_valid               (input_valid),
        .glob_scen_noc_input_valid (glob_valid),
        .busy                      (busy),
        .state_o                   (state_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Phase timeline in listed order; RUN (13) follows the last entry.
    int ph_state[$];
    int ph_dur[$];
    int idx_tblup;

    function automatic int state_at(input int first, input int el);
        int e = el;
        for (int i = first; i < ph_state.size(); i++) begin
            if (e < ph_dur[i]) return ph_state[i];
            e -= ph_dur[i];
        end
        return 13;
    endfunction

    function automatic logic is_boot(input int s);
        return (s == 6) || (s == 7);
    endfunction

    int   m_state = 0;
    int   m_t0 = 0;
    int   m_first = 0;
    bit   m_active = 0;
    logic m_ws = 0, m_iv = 0, m_gv = 0;

    // Model update at each edge, compare one time unit later.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_state = 0; m_active = 0; m_ws = 0; m_iv = 0; m_gv = 0;
        end else begin
            m_iv = dft & is_boot(m_state);
            m_gv = dft & ~is_boot(m_state) & (m_state != 0);
            if (m_state == 0 && go) begin
                m_active = 1; m_t0 = cyc; m_first = 0;
            end else if (m_state == 13 && rescen) begin
                m_t0 = cyc; m_first = idx_tblup;
            end
            if (m_active) m_state = state_at(m_first, cyc - m_t0);
            if (m_state == 12) m_ws = 1;
        end
        #1;
        chk("state_o", state_o, m_state);
        chk("init_sram", init_sram, m_state == 1);
        chk("soft_reset", soft_reset, m_state == 2);
        chk("load", load, m_state == 4);
        chk("upload", upload, m_state == 6 || m_state == 9);
        chk("boot_up", boot_up, is_boot(m_state));
        chk("table_parse", table_parse, m_state >= 8);
        chk("boot_up_local", boot_up_local, m_state == 8);
        chk("tbl_update", boot_up_table_update, m_state == 10);
        chk("start", start, m_state == 12);
        chk("write_start", write_start, m_ws);
        chk("input_valid", input_valid, m_iv);
        chk("glob_valid", glob_valid, m_gv);
        chk("busy", busy, !(m_state == 0 || m_state == 12 || m_state == 13));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs until start is seen, recording phase landmarks along the way.
    task automatic run_seq(input bit toggle, input bit inject, output int start_at,
                           output int n_init, output int load_at, output int up_first,
                           output int up_last, output int upd_at, output bit sticky_drop);
        bit did_go = 0, did_rs = 0;
        start_at = -1; n_init = 0; load_at = -1; up_first = -1; up_last = -1;
        upd_at = -1; sticky_drop = 0;
        for (int n = 0; n < 3000; n++) begin
            if (init_sram) n_init++;
            if (load && load_at < 0) load_at = cyc;
            if (upload && up_first < 0) up_first = cyc;
            if (upload) up_last = cyc;
            if (boot_up_table_update) upd_at = cyc;
            if (start) begin
                start_at = cyc;
                chk("busy_at_start", busy, 0);
                chk("ws_at_start", write_start, 1);
                break;
            end
            go = 0; rescen = 0;
            if (inject && boot_up_local && !did_go) begin go = 1; did_go = 1; end
            if (inject && state_o == 4'hB && !did_rs) begin rescen = 1; did_rs = 1; end
            if (m_first != 0 && (!table_parse || !write_start)) sticky_drop = 1;
            dft = toggle ? ~dft : 1'($urandom);
            tick();
        end
        go = 0; rescen = 0;
        if (start_at < 0) chk("start_timeout", 0, 1);
    endtask

    int c_go, s_at, n_init, l_at, u_f, u_l, upd;
    bit drop;

    initial begin
`ifdef DRBE_SEQ_SRAM_INIT_EN
        ph_state = {1, 2, 3};
        ph_dur   = {1050, 3, 6};
`endif
        ph_state = {ph_state, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        ph_dur   = {ph_dur, 1, 6, 20, 6, 38, 26, 1, 85, 1};
        foreach (ph_state[i]) if (ph_state[i] == 9) idx_tblup = i;

        rst = 1; go = 0; rescen = 0; dft = 0;
        repeat (3) tick();
        rst = 0;
        chk("reset_outputs", {init_sram, soft_reset, load, upload, boot_up, table_parse,
            boot_up_local, boot_up_table_update, start, write_start, input_valid,
            glob_valid, busy, state_o}, 0);

        // rescen in IDLE is dropped
        rescen = 1; tick(); rescen = 0;
        chk("idle_rescen_ignored", state_o, 0);
        while (cyc < 10) tick();
        go = 1; c_go = cyc; tick(); go = 0;
        chk("init_first", init_sram, EXP_INIT != 0);
        chk("load_first", load, EXP_INIT == 0);
        run_seq(1, 1, s_at, n_init, l_at, u_f, u_l, upd, drop);
        chk("boot_start_cycle", s_at, c_go + EXP_START);
        chk("boot_init_len", n_init, EXP_INIT);
        chk("boot_load_cycle", l_at, c_go + EXP_LOAD);
        tick();
        chk("run_state", state_o, 13);
        chk("run_busy", busy, 0);
        chk("run_ws", write_start, 1);

        // Scenario-change loops; the second one also raises go alongside rescen.
        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(1, 20)) begin dft = 1'($urandom); tick(); end
            rescen = 1; go = (it == 1);
            c_go = cyc; tick(); rescen = 0; go = 0;
            run_seq(0, 1, s_at, n_init, l_at, u_f, u_l, upd, drop);
            chk("rs_up_first", u_f, c_go + 1);
            chk("rs_up_last", u_l, c_go + 26);
            chk("rs_upd", upd, c_go + 27);
            chk("rs_start", s_at, c_go + 113);
            chk("rs_sticky", drop, 0);
            tick();
        end

        // Reset mid-phase, then a full restart.
        rst = 1; tick(); rst = 0; tick();
        go = 1; c_go = cyc; tick(); go = 0;
        while (cyc < c_go + RST_AT) begin dft = 1'($urandom); tick(); end
        rst = 1; dft = 1; tick(); rst = 0;
        chk("mid_reset_outputs", {init_sram, soft_reset, load, upload, boot_up, table_parse,
            boot_up_local, boot_up_table_update, start, write_start, input_valid,
            glob_valid, busy, state_o}, 0);
        go = 1; c_go = cyc; tick(); go = 0;
        run_seq(0, 0, s_at, n_init, l_at, u_f, u_l, upd, drop);
        chk("restart_init_len", n_init, EXP_INIT);
        chk("restart_start", s_at, c_go + EXP_START);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            go     = ($urandom_range(0, 39) == 0);
            rescen = ($urandom_range(0, 29) == 0);
            rst    = ($urandom_range(0, 1499) == 0);
            dft    = 1'($urandom);
            tick();
        end
        go = 0; rescen = 0; rst = 0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
